// File: rtl/breakout_game_ctrl.sv
// Breakout game sequencer: button conditioning, game FSM and lives/score/brick counters.
// The ball/paddle/brick datapath is only stepped while this block enables it.
module breakout_game_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned LIVES           = 3,
  parameter int unsigned BRICKS          = 40,
  parameter int unsigned SERVE_FRAMES    = 60,
  parameter int unsigned POINTS          = 10
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        frame_tick,
  input  logic        btn_up,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        ball_lost,
  input  logic        brick_hit,
  output logic [2:0]  state,
  output logic        paddle_left,
  output logic        paddle_right,
  output logic        ball_enable,
  output logic        ball_reset,
  output logic        bricks_reset,
  output logic [2:0]  lives,
  output logic [7:0]  bricks_left,
  output logic [11:0] score,
  output logic [4:0]  led
);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StServe    = 3'd1,
    StPlay     = 3'd2,
    StLifeLost = 3'd3,
    StWin      = 3'd4,
    StGameOver = 3'd5
  } state_e;

  localparam logic [19:0] DbMax     = 20'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]  ServeMax  = 8'(SERVE_FRAMES - 1);
  localparam logic [12:0] Pts       = 13'(POINTS);
  localparam logic [2:0]  LivesInit = 3'(LIVES);
  localparam logic [7:0]  BrickInit = 8'(BRICKS);

  // Button index: 0 = up, 1 = left, 2 = right.
  logic [2:0]  btn_raw;
  logic [2:0]  sync1_q, sync2_q, level_q;
  logic [19:0] cnt_q [3];
  logic        up_prev_q, up_press_q;

  assign btn_raw = {btn_right, btn_left, btn_up};

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      level_q    <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      up_prev_q  <= 1'b0;
      up_press_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] == level_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == DbMax) begin
          level_q[i] <= ~level_q[i];
          cnt_q[i]   <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 20'd1;
        end
      end
      up_prev_q  <= level_q[0];
      up_press_q <= level_q[0] & ~up_prev_q;
    end
  end

  state_e      state_q;
  logic [7:0]  frame_cnt_q;
  logic [2:0]  lives_q;
  logic [7:0]  bricks_q;
  logic [11:0] score_q;
  logic        ball_reset_q, bricks_reset_q;
  logic [12:0] score_sum;

  assign score_sum = {1'b0, score_q} + Pts;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q        <= StIdle;
      frame_cnt_q    <= '0;
      lives_q        <= LivesInit;
      bricks_q       <= BrickInit;
      score_q        <= '0;
      ball_reset_q   <= 1'b0;
      bricks_reset_q <= 1'b0;
    end else begin
      ball_reset_q   <= 1'b0;
      bricks_reset_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (up_press_q) begin
            lives_q        <= LivesInit;
            score_q        <= '0;
            bricks_q       <= BrickInit;
            frame_cnt_q    <= '0;
            ball_reset_q   <= 1'b1;
            bricks_reset_q <= 1'b1;
            state_q        <= StServe;
          end
        end
        StServe: begin
          if (frame_tick) frame_cnt_q <= frame_cnt_q + 8'd1;
          if (up_press_q || (frame_tick && frame_cnt_q == ServeMax)) state_q <= StPlay;
        end
        StPlay: begin
          if (brick_hit && bricks_q != 8'd0) begin
            bricks_q <= bricks_q - 8'd1;
            score_q  <= (score_sum > 13'd4095) ? 12'd4095 : score_sum[11:0];
          end
          if (ball_lost && lives_q != 3'd0) lives_q <= lives_q - 3'd1;
          // The last brick wins even if the ball was lost in the same cycle.
          if (brick_hit && bricks_q == 8'd1) state_q <= StWin;
          else if (ball_lost)                state_q <= StLifeLost;
        end
        StLifeLost: begin
          if (lives_q == 3'd0) begin
            state_q <= StGameOver;
          end else if (frame_tick) begin
            frame_cnt_q  <= '0;
            ball_reset_q <= 1'b1;
            state_q      <= StServe;
          end
        end
        StWin, StGameOver: begin
          if (up_press_q) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign state        = state_q;
  assign ball_enable  = (state_q == StPlay);
  assign paddle_left  = level_q[1] & (state_q == StServe || state_q == StPlay);
  assign paddle_right = level_q[2] & (state_q == StServe || state_q == StPlay);
  assign ball_reset   = ball_reset_q;
  assign bricks_reset = bricks_reset_q;
  assign lives        = lives_q;
  assign bricks_left  = bricks_q;
  assign score        = score_q;

  always_comb begin
    led = '0;
    for (int i = 0; i < 5; i++) led[i] = (lives_q > 3'(i));
  end

endmodule

// File: doc/breakout_game_ctrl.md
# breakout_game_ctrl

Game sequencer for the breakout design, sitting between the board push-buttons, the VGA frame timing and the ball/paddle/brick datapath inside `breakout_top`. It conditions the raw buttons (synchronise and debounce) and runs the game state machine IDLE → SERVE → PLAY → LIFE_LOST/WIN/GAME_OVER. It also owns the lives, score and bricks-remaining counters. The datapath is only stepped when this block enables it.

## Interface
- `DEBOUNCE_CYCLES`, 1000000: consecutive stable `sys_clk` cycles required to accept a button level change (20 ms at 50 MHz); legal range 1..2^20-1.
- `LIVES`, 3: lives per game; legal range 1..7.
- `BRICKS`, 40: bricks in a full wall; legal range 1..255.
- `SERVE_FRAMES`, 60: frames the ball is held before auto-launch; legal range 1..255.
- `POINTS`, 10: score added per brick; legal range 1..255.

- `sys_clk`  in  1  system clock, 50 MHz.
- `sys_rst`  in  1  asynchronous, active-high reset.
- `frame_tick`  in  1  one-cycle pulse per frame from VGA timing.
- `btn_up`, `btn_left`, `btn_right`  in  1 each  raw buttons, active-high, asynchronous to `sys_clk`.
- `ball_lost`  in  1  one-cycle pulse when the ball exits the bottom edge.
- `brick_hit`  in  1  one-cycle pulse per brick destroyed.
- `state`  out  3  IDLE=0, SERVE=1, PLAY=2, LIFE_LOST=3, WIN=4, GAME_OVER=5.
- `paddle_left`, `paddle_right`  out  1 each  debounced levels, gated to SERVE/PLAY.
- `ball_enable`  out  1  high only in PLAY.
- `ball_reset`  out  1  pulse: re-centre the ball on the paddle.
- `bricks_reset`  out  1  pulse: restore the full brick wall.
- `lives`  out  3  lives remaining.
- `bricks_left`  out  8  bricks remaining.
- `score`  out  12  accumulated score, saturating.
- `led`  out  5  thermometer of lives: `led[i] = (lives > i)`.

## Operation
- **Button path.** Each button passes through a 2-flop synchroniser, then a debouncer.
  - The debouncer holds a debounced level (reset 0) and a 20-bit counter.
  - The counter clears whenever the synced level equals the debounced level, and increments otherwise.
  - When the counter reaches `DEBOUNCE_CYCLES`, the debounced level flips and the counter clears.
  - `up_press` is a one-cycle pulse on the rising edge of debounced up.
- **IDLE.**
  - `up_press` starts a new game: `lives←LIVES`, `score←0`, `bricks_left←BRICKS`, then go to SERVE.
  - `bricks_reset` is asserted for the first cycle in SERVE of a new game only.
- **SERVE.**
  - `ball_reset` is high for exactly the first cycle of every SERVE entry.
  - The frame counter clears on entry and increments on each `frame_tick`.
  - Go to PLAY when the counter reaches `SERVE_FRAMES` or on `up_press`, whichever comes first.
- **PLAY.**
  - On `brick_hit`: `bricks_left−1`; `score+POINTS`, saturating at 4095.
  - If `bricks_left` becomes 0, go to WIN.
  - On `ball_lost`: `lives−1`, go to LIFE_LOST.
  - If `brick_hit` and `ball_lost` arrive in the same cycle, both counters update. WIN takes priority if the last brick fell; otherwise go to LIFE_LOST.
- **LIFE_LOST.**
  - If `lives==0`, go to GAME_OVER on the next cycle.
  - Otherwise wait for the next `frame_tick`, then go to SERVE (which pulses `ball_reset`).
- **WIN / GAME_OVER.**
  - Hold all counters; `up_press` goes to IDLE.
- **Ignored inputs.** `brick_hit` and `ball_lost` outside PLAY are ignored. `lives` never underflows.
- **Paddle gating.** `paddle_left`/`paddle_right` equal the debounced levels in SERVE and PLAY, and 0 elsewhere.

## Timing
- **Reset values:**
  - `state`=IDLE, `lives`=`LIVES`, `bricks_left`=`BRICKS`, `score`=0.
  - `led` = thermometer of `LIVES`.
  - All pulses, paddle outputs, `ball_enable` and debounced levels = 0.
- **Registered outputs.** All outputs are registered. An input sampled at edge N is reflected in the outputs after edge N.
- **Button latency.** From a clean raw edge to the debounced level change: 2 synchroniser cycles + `DEBOUNCE_CYCLES`. `up_press` appears on the cycle after the debounced rise.
- **Bounce.** A bounce shorter than `DEBOUNCE_CYCLES` produces no change.
- **State latency.** State changes one cycle after the triggering event; `ball_enable` follows `state` combinationally from the state register.
- **Reset mid-operation.** Reset asserted mid-game returns to reset values immediately, asynchronously. Release is synchronous in effect; the first transition is possible on the first edge after deassertion.

## Test plan
Parameters for all scenarios: `DEBOUNCE_CYCLES`=4, `LIVES`=2, `BRICKS`=3, `SERVE_FRAMES`=2, `POINTS`=10.
- **Reset.** Assert `sys_rst` → `state`=0, `lives`=2, `bricks_left`=3, `score`=0, `led`=5'b00011, all pulses 0.
- **Debounce.** Toggle `btn_up` high for 3 cycles, then low → no `up_press`. Hold high for 10 cycles → exactly one `up_press` at cycle 2+4+1 after the edge.
- **Start and auto-launch.** Press up in IDLE → `bricks_reset` and `ball_reset` each high 1 cycle, `state`=1. After 2 `frame_tick`s → `state`=2, `ball_enable`=1.
- **Score and win.** Three `brick_hit` pulses in PLAY → `score`=30, `bricks_left`=0, `state`=4. Further `brick_hit` pulses leave the counters unchanged.
- **Lives to game over.**
  - `ball_lost` → `lives`=1, `state`=3; at the next `frame_tick` → SERVE with a `ball_reset` pulse.
  - Second `ball_lost` → `lives`=0, then `state`=5 one cycle later, `led`=0.
  - `up_press` → IDLE.
- **Simultaneous last brick and lost ball.** `brick_hit` and `ball_lost` in the same cycle with `bricks_left`=1 → `state`=4, `lives` decremented, `bricks_left`=0.
